// File: rtl/csr_rmw_ctrl.sv
// Purpose: sequences Zicsr read-modify-write on the single CSR file port and gives trap writes priority.
// Latency: Zicsr accept T, read T+1, write/rd strobe T+2, idle T+3; trap writes take effect the same cycle from IDLE.
// Backpressure: req_ready_o/trap_ready_o low while busy; a trap beats a same-cycle request; a trap waits at most 2 cycles.
module csr_rmw_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_control_i,
    input  logic              req_src_i,
    input  logic [XLEN-1:0]   req_rs1_data_i,
    input  logic [4:0]        req_uimm_i,
    input  logic              req_zero_src_i,
    output logic              req_ready_o,
    output logic              busy_o,
    input  logic              flush_i,
    output logic              rd_valid_o,
    output logic [XLEN-1:0]   rd_data_o,
    input  logic              trap_valid_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic [XLEN-1:0]   trap_wdata_i,
    output logic              trap_ready_o,
    output logic [ADDR_W-1:0] csr_addr_o,
    output logic              csr_re_o,
    input  logic [XLEN-1:0]   csr_rdata_i,
    output logic              csr_we_o,
    output logic [XLEN-1:0]   csr_wdata_o
);

    // funct3[1:0] encodings and funct3[2] operand source
    localparam logic [1:0] CSR_NA    = 2'b00;
    localparam logic [1:0] CSR_PASS  = 2'b01;
    localparam logic [1:0] CSR_SET   = 2'b10;
    localparam logic [1:0] CSR_CLEAR = 2'b11;
    localparam logic       CSR_SRC_REG = 1'b0;
    localparam logic       CSR_SRC_IMM = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              zero_q, zero_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic [XLEN-1:0]   req_opnd;

    // Select the request operand: rs1 data or zero-extended uimm
    always_comb begin
        req_opnd = req_rs1_data_i;
        case (req_src_i)
            CSR_SRC_REG: req_opnd = req_rs1_data_i;
            CSR_SRC_IMM: req_opnd = {{(XLEN-5){1'b0}}, req_uimm_i};
        endcase
    end

    // Next-state and port outputs; all outputs forced low while reset is held
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        ctrl_d       = ctrl_q;
        opnd_d       = opnd_q;
        zero_d       = zero_q;
        old_d        = old_q;
        req_ready_o  = 1'b0;
        busy_o       = 1'b0;
        rd_valid_o   = 1'b0;
        rd_data_o    = '0;
        trap_ready_o = 1'b0;
        csr_addr_o   = '0;
        csr_re_o     = 1'b0;
        csr_we_o     = 1'b0;
        csr_wdata_o  = '0;
        case (state_q)
            IDLE: begin
                if (trap_valid_i) begin
                    // trap owns the port; the request waits for the next free IDLE cycle
                    csr_addr_o   = trap_addr_i;
                    csr_wdata_o  = trap_wdata_i;
                    csr_we_o     = 1'b1;
                    trap_ready_o = 1'b1;
                end else if (req_valid_i) begin
                    req_ready_o = 1'b1;
                    if (req_control_i != CSR_NA) begin
                        csr_re_o   = 1'b1;
                        csr_addr_o = req_addr_i;
                        addr_d     = req_addr_i;
                        ctrl_d     = req_control_i;
                        opnd_d     = req_opnd;
                        zero_d     = req_zero_src_i;
                        state_d    = READ;
                    end
                end
            end
            READ: begin
                busy_o  = 1'b1;
                old_d   = csr_rdata_i;
                state_d = flush_i ? IDLE : WRITE;
            end
            WRITE: begin
                // commit point: flush no longer has any effect here
                busy_o     = 1'b1;
                csr_addr_o = addr_q;
                rd_valid_o = 1'b1;
                rd_data_o  = old_q;
                case (ctrl_q)
                    CSR_SET:   csr_wdata_o = old_q | opnd_q;
                    CSR_CLEAR: csr_wdata_o = old_q & ~opnd_q;
                    CSR_PASS:  csr_wdata_o = opnd_q;
                    default:   csr_wdata_o = opnd_q;
                endcase
                // set/clear with a zero source are pure reads
                csr_we_o = !(((ctrl_q == CSR_SET) || (ctrl_q == CSR_CLEAR)) && zero_q);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n_i) begin
            req_ready_o  = 1'b0;
            busy_o       = 1'b0;
            rd_valid_o   = 1'b0;
            rd_data_o    = '0;
            trap_ready_o = 1'b0;
            csr_addr_o   = '0;
            csr_re_o     = 1'b0;
            csr_we_o     = 1'b0;
            csr_wdata_o  = '0;
        end
    end

    // State and latched request fields; reset aborts any sequence in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ctrl_q  <= CSR_NA;
            opnd_q  <= '0;
            zero_q  <= 1'b0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ctrl_q  <= ctrl_d;
            opnd_q  <= opnd_d;
            zero_q  <= zero_d;
            old_q   <= old_d;
        end
    end

endmodule

// File: doc/csr_rmw_ctrl.md
# csr_rmw_ctrl

Sequencer for the single read/write port of the CSR register file. It sits between the execute stage and the trap unit on one side and the CSR file on the other. It runs each Zicsr instruction as a 3-cycle read-modify-write (read, compute, write back), and returns the old CSR value to the pipeline. It also gives the trap unit's single-cycle CSR writes (mepc, mcause, mtval) priority access to the port.

## Interface
Parameters:
- XLEN, 32, CSR data width.
- ADDR_W, 12, CSR address width.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  execute-stage Zicsr request.
- req_addr_i  in  ADDR_W  target CSR.
- req_control_i  in  2  `CSR_PASS` / `CSR_SET` / `CSR_CLEAR` / `CSR_NA`, as decoded from funct3.
- req_src_i  in  1  `CSR_SRC_REG` (rs1 data) or `CSR_SRC_IMM` (uimm).
- req_rs1_data_i  in  XLEN  rs1 operand.
- req_uimm_i  in  5  immediate operand, zero-extended to XLEN.
- req_zero_src_i  in  1  rs1 index or uimm field is zero (write-suppress qualifier).
- req_ready_o  out  1  request accepted this cycle.
- busy_o  out  1  sequence in progress; pipeline stalls on this.
- flush_i  in  1  squash the in-flight pipeline request.
- rd_valid_o  out  1  one-cycle strobe; rd_data_o is valid.
- rd_data_o  out  XLEN  old CSR value for rd.
- trap_valid_i  in  1  trap unit write request.
- trap_addr_i  in  ADDR_W  trap target CSR.
- trap_wdata_i  in  XLEN  trap write data.
- trap_ready_o  out  1  trap write performed this cycle.
- csr_addr_o  out  ADDR_W  CSR file address.
- csr_re_o  out  1  CSR file read enable; the file has synchronous read, data valid the next cycle.
- csr_rdata_i  in  XLEN  CSR file read data.
- csr_we_o  out  1  CSR file write enable.
- csr_wdata_o  out  XLEN  CSR file write data.

## Operation
- FSM states are IDLE, READ and WRITE.
- IDLE with trap_valid_i high:
  - csr_addr_o = trap_addr_i, csr_wdata_o = trap_wdata_i, csr_we_o = 1, trap_ready_o = 1.
  - The FSM stays in IDLE and req_ready_o = 0.
- IDLE with no trap, req_valid_i high and control != `CSR_NA`:
  - req_ready_o = 1, csr_re_o = 1, csr_addr_o = req_addr_i.
  - Latch addr, control, operand and zero_src, then go to READ.
  - Operand = rs1 data if src is `CSR_SRC_REG`, else {27'b0, uimm}.
- IDLE with control == `CSR_NA`: req_ready_o = 1, no CSR access, no rd_valid_o, stay in IDLE.
- READ:
  - Latch csr_rdata_i as old value.
  - If flush_i is high, return to IDLE with no write and no rd_valid_o.
  - Otherwise go to WRITE.
- WRITE:
  - csr_addr_o = latched addr; rd_valid_o = 1, rd_data_o = old value. Return to IDLE.
  - csr_wdata_o by latched control: PASS = operand, SET = old | operand, CLEAR = old & ~operand.
  - csr_we_o = 1, except for SET or CLEAR with the latched zero_src set; those are read-only and write is suppressed.
  - flush_i is ignored in WRITE; this is the commit point.
- Trap requests arriving in READ or WRITE wait: trap_ready_o = 0 until the FSM is back in IDLE.
- busy_o = 1 in READ and WRITE.
- csr_re_o, csr_we_o, trap_ready_o, req_ready_o and rd_valid_o are 0 unless stated above. At most one of csr_re_o and csr_we_o is high in any cycle.

## Timing
- Reset:
  - State goes to IDLE asynchronously; the latched old value and operand clear to 0.
  - While rst_n_i is low, every output is 0, including req_ready_o and trap_ready_o.
  - Reset in READ or WRITE aborts the sequence: no write, no rd_valid_o.
- Pipeline request accepted in cycle T: READ at T+1, WRITE at T+2 (write and rd_valid_o), IDLE at T+3.
- Throughput is one Zicsr request per 3 cycles.
- busy_o is high in T+1 and T+2. The pipeline must hold req_* stable until req_ready_o is high.
- Trap write latency is 0 cycles from IDLE. Worst-case trap wait is 2 cycles.
- Simultaneous trap and pipeline request in IDLE: trap wins that cycle, and the request is accepted the next IDLE cycle with no trap pending.
- A WRITE cycle followed by a new request: the new read in the next IDLE cycle sees the written value, because the file writes on the clock edge.

## Test plan
- Reset: hold rst_n_i low mid-READ → all outputs 0; after release, req_ready_o = 1 with req_valid_i high and no trap.
- CSRRW: mscratch = 0x1234, operand 0xDEADBEEF → rd_data_o = 0x1234 at T+2, csr_wdata_o = 0xDEADBEEF with we = 1; a second read returns 0xDEADBEEF.
- CSRRS / CSRRC: old = 0xF0F0, uimm = 5'h0F → SET writes 0xF0FF; CLEAR on old 0xF0FF with operand 0xFF writes 0xF000.
- Write suppress: CSRRS with zero_src = 1 on mstatus = 0x88 → rd_data_o = 0x88 and csr_we_o stays 0 throughout.
- Arbitration: trap_valid_i and req_valid_i rise together → trap write in cycle T, request accepted at T+1. A trap raised during READ waits until IDLE, 2 cycles later.
- Flush: flush_i high in READ → no write, no rd_valid_o, IDLE next cycle. flush_i high in WRITE → write and rd_valid_o still occur.
